// File: rtl/neo_frame_sequencer.sv
// neo_frame_sequencer: replays a double-buffered NeoPixel frame into the strand
// controller load interface, then requests a send. Supports single-shot, auto
// refresh and chase (per-frame rotation of the pixel mapping).
module neo_frame_sequencer #(
    parameter int NUM_PIXELS   = 5,
    parameter int FRAME_PERIOD = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_pixel,
    input  logic [1:0]  wr_color,
    input  logic [7:0]  wr_level,
    input  logic        start,
    input  logic        auto_mode,
    input  logic        rotate,
    input  logic        ready_to_load,
    input  logic        ready_to_send,
    output logic [2:0]  pixel_index,
    output logic [1:0]  color_index,
    output logic [7:0]  color_level,
    output logic        load_color,
    output logic        send_it,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count
);
    localparam int HW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [2:0]    LAST_P = 3'(NUM_PIXELS - 1);
    // Pixel count folded to 3 bits; 8 pixels wraps to 0, which keeps the
    // modular offset arithmetic below correct for every legal size.
    localparam logic [2:0]    NP3    = 3'(NUM_PIXELS);
    localparam logic [HW-1:0] LAST_H = HW'(FRAME_PERIOD - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [2:0]    p_q, p_d;
    logic [1:0]    c_q, c_d;
    logic [2:0]    offset_q, offset_d;
    logic          seen_low_q, seen_low_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0]   count_q, count_d;
    logic          copy;

    // Arrays sized for the 3-bit pixel index; entries at or above NUM_PIXELS
    // are never written and stay zero.
    logic [7:0] shadow_q [8][3];
    logic [7:0] active_q [8][3];

    logic       wr_ok;
    logic [2:0] thresh;
    logic [2:0] src_p;

    assign wr_ok  = wr_en && ({1'b0, wr_pixel} < 4'(NUM_PIXELS)) && (wr_color != 2'd3);
    // (p + offset) mod NUM_PIXELS without a wide adder: subtract the distance
    // to the wrap point when p has reached it.
    assign thresh = NP3 - offset_q;
    assign src_p  = (p_q >= thresh) ? (p_q - thresh) : (p_q + offset_q);

    assign busy        = (state_q != S_IDLE);
    assign frame_count = count_q;
    assign pixel_index = (state_q == S_LOAD) ? p_q : 3'd0;
    assign color_index = (state_q == S_LOAD) ? c_q : 2'd0;
    assign color_level = (state_q == S_LOAD) ? active_q[src_p][c_q] : 8'd0;

    // Next-state logic and handshake strobes for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        c_d        = c_q;
        offset_d   = offset_q;
        seen_low_d = seen_low_q;
        hold_d     = hold_q;
        count_d    = count_q;
        copy       = 1'b0;
        load_color = 1'b0;
        send_it    = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start || auto_mode) begin
                    state_d = S_LOAD;
                    p_d     = 3'd0;
                    c_d     = 2'd0;
                    copy    = 1'b1;
                end
            end
            S_LOAD: begin
                if (ready_to_load) begin
                    load_color = 1'b1;
                    if (c_q == 2'd2) begin
                        c_d = 2'd0;
                        if (p_q == LAST_P) begin
                            p_d     = 3'd0;
                            state_d = S_SEND;
                        end else begin
                            p_d = p_q + 3'd1;
                        end
                    end else begin
                        c_d = c_q + 2'd1;
                    end
                end
            end
            S_SEND: begin
                if (ready_to_send) begin
                    send_it    = 1'b1;
                    seen_low_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // The strand drops ready_to_load while shifting and latching;
                // its return marks the end of the frame.
                if (!ready_to_load) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    frame_done = 1'b1;
                    count_d    = count_q + 16'd1;
                    if (rotate) begin
                        offset_d = (offset_q == LAST_P) ? 3'd0 : offset_q + 3'd1;
                    end
                    hold_d  = '0;
                    state_d = auto_mode ? S_HOLD : S_IDLE;
                end
            end
            S_HOLD: begin
                if (hold_q == LAST_H) begin
                    if (auto_mode) begin
                        state_d = S_LOAD;
                        p_d     = 3'd0;
                        c_d     = 2'd0;
                        copy    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // No strobe may escape while reset is being applied.
        if (reset) begin
            load_color = 1'b0;
            send_it    = 1'b0;
            frame_done = 1'b0;
        end
    end

    // State, counters and frame buffers; a write coinciding with the copy
    // lands in shadow only because the copy reads the pre-edge shadow.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            p_q        <= 3'd0;
            c_q        <= 2'd0;
            offset_q   <= 3'd0;
            seen_low_q <= 1'b0;
            hold_q     <= '0;
            count_q    <= 16'd0;
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 3; j++) begin
                    shadow_q[i][j] <= 8'd0;
                    active_q[i][j] <= 8'd0;
                end
            end
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            c_q        <= c_d;
            offset_q   <= offset_d;
            seen_low_q <= seen_low_d;
            hold_q     <= hold_d;
            count_q    <= count_d;
            if (copy) begin
                active_q <= shadow_q;
            end
            if (wr_ok) begin
                shadow_q[wr_pixel][wr_color] <= wr_level;
            end
        end
    end
endmodule

// File: tb/tb_neo_frame_sequencer.sv
// Self-checking bench for neo_frame_sequencer: load scoreboard, write and
// handshake vector tables, plus sequences for stall, rotation and reset.
module tb_neo_frame_sequencer;
    localparam int NP = 5;
    localparam int FP = 20;

    logic        clock = 1'b0;
    logic        reset, wr_en, start, auto_mode, rotate, rl, rs;
    logic [2:0]  wr_pixel;
    logic [1:0]  wr_color;
    logic [7:0]  wr_level;
    logic [2:0]  pixel_index;
    logic [1:0]  color_index;
    logic [7:0]  color_level;
    logic        load_color, send_it, busy, frame_done;
    logic [15:0] frame_count;

    neo_frame_sequencer #(.NUM_PIXELS(NP), .FRAME_PERIOD(FP)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_pixel(wr_pixel),
        .wr_color(wr_color), .wr_level(wr_level), .start(start),
        .auto_mode(auto_mode), .rotate(rotate), .ready_to_load(rl),
        .ready_to_send(rs), .pixel_index(pixel_index), .color_index(color_index),
        .color_level(color_level), .load_color(load_color), .send_it(send_it),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [2:0] p; logic [1:0] c; logic [7:0] lvl; } load_t;
    typedef struct { logic [2:0] pix; logic [1:0] col; logic [7:0] lvl; bit takes; } wr_vec_t;
    typedef struct { logic rl; logic done; logic busy; } hs_vec_t;

    load_t   exp_q[$];
    wr_vec_t wtab[18];
    hs_vec_t htab[6];

    int checks = 0, failures = 0;
    int loads_seen = 0, sends_seen = 0, done_seen = 0;
    logic       s_load, s_send, s_done, s_busy;
    logic [2:0] s_pix;
    logic [1:0] s_col;
    logic [7:0] s_lvl;
    logic [7:0] exp_shadow [NP][3];
    logic [7:0] exp_act    [NP][3];
    int exp_off = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        load_t e;
        s_load = load_color; s_send = send_it; s_done = frame_done; s_busy = busy;
        s_pix = pixel_index; s_col = color_index; s_lvl = color_level;
        if (s_load) begin
            loads_seen++;
            chk("load_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("load_pix_col_lvl", {19'd0, s_pix, s_col, s_lvl}, {19'd0, e});
            end
        end
        if (s_send) sends_seen++;
        if (s_done) done_seen++;
    endtask

    task automatic cycle();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
    endtask

    task automatic push_frame(input int off);
        load_t e;
        for (int p = 0; p < NP; p++) begin
            for (int c = 0; c < 3; c++) begin
                e.p = 3'(p); e.c = 2'(c); e.lvl = exp_act[(p + off) % NP][c];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_frame(input bit do_stall, input bit do_write,
                             input bit do_startwrite, input bit do_busystart);
        int n, k, l0, s0, stall_n;
        bit wrote;
        exp_act = exp_shadow;
        push_frame(exp_off);
        l0 = loads_seen; s0 = sends_seen; stall_n = 0; wrote = 0;
        start = 1; rl = 1;
        if (do_startwrite) begin
            wr_en = 1; wr_pixel = 3'd1; wr_color = 2'd2; wr_level = 8'h5C;
            exp_shadow[1][2] = 8'h5C;
        end
        cycle();
        start = 0; wr_en = 0;
        n = 0;
        while (sends_seen == s0 && n < 60) begin
            k = loads_seen - l0;
            rl = 1; start = 0; wr_en = 0;
            if (do_stall && k == 7 && stall_n < 3) begin rl = 0; stall_n++; end
            if (do_write && k == 3 && !wrote) begin
                wr_en = 1; wr_pixel = 3'd4; wr_color = 2'd1; wr_level = 8'hA5;
                exp_shadow[4][1] = 8'hA5; wrote = 1;
            end
            if (do_busystart && k >= 4 && k < 6) start = 1;
            cycle();
            n++;
            if (rl == 0) begin
                chk("stall_no_load", 32'(s_load), 0);
                if (exp_q.size() > 0)
                    chk("stall_fields_hold", {27'd0, s_pix, s_col}, {27'd0, exp_q[0].p, exp_q[0].c});
            end
        end
        start = 0; wr_en = 0; rl = 1;
        chk("load_send_cycles", n, do_stall ? 19 : 16);
        chk("all_loads_done", exp_q.size(), 0);
    endtask

    task automatic handshake();
        int c0;
        c0 = int'(frame_count);
        rl = 1; cycle(); chk("no_done_before_low", 32'(s_done), 0);
        rl = 0; cycle(); chk("no_done_while_low", 32'(s_done), 0);
        rl = 1; cycle(); chk("frame_done_on_rise", 32'(s_done), 1);
        chk("frame_count_inc", 32'(frame_count), 32'(16'(c0 + 1)));
    endtask

    initial begin
        int n, m, s0;
        reset = 1; wr_en = 0; start = 0; auto_mode = 0; rotate = 0; rl = 0; rs = 0;
        wr_pixel = 0; wr_color = 0; wr_level = 0;
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++) begin
                exp_shadow[p][c] = 8'd0;
                wtab[p * 3 + c] = '{3'(p), 2'(c), 8'(16 * p + c), 1'b1};
            end
        wtab[15] = '{3'd6, 2'd0, 8'hEE, 1'b0};
        wtab[16] = '{3'd3, 2'd3, 8'hEE, 1'b0};
        wtab[17] = '{3'd7, 2'd2, 8'hBB, 1'b0};
        htab[0] = '{1'b1, 1'b0, 1'b1};
        htab[1] = '{1'b0, 1'b0, 1'b1};
        htab[2] = '{1'b0, 1'b0, 1'b1};
        htab[3] = '{1'b1, 1'b1, 1'b1};
        htab[4] = '{1'b1, 1'b0, 1'b0};
        htab[5] = '{1'b0, 1'b0, 1'b0};

        // reset state
        cycle(); cycle();
        reset = 0;
        cycle();
        chk("reset_outputs", {12'd0, s_load, s_send, s_busy, s_done, s_pix, s_col, s_lvl}, 0);
        chk("reset_count", 32'(frame_count), 0);

        // buffer writes from the vector table
        for (int i = 0; i < 18; i++) begin
            wr_en = 1; wr_pixel = wtab[i].pix; wr_color = wtab[i].col; wr_level = wtab[i].lvl;
            cycle();
            if (wtab[i].takes) exp_shadow[wtab[i].pix][wtab[i].col] = wtab[i].lvl;
        end
        wr_en = 0;

        // basic frame plus table-driven completion handshake
        rs = 1;
        run_frame(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            rl = htab[i].rl;
            cycle();
            chk($sformatf("hs_done_%0d", i), 32'(s_done), 32'(htab[i].done));
            chk($sformatf("hs_busy_%0d", i), 32'(s_busy), 32'(htab[i].busy));
        end
        chk("count_after_first", 32'(frame_count), 1);
        rl = 1;

        // stall mid-load
        run_frame(1, 0, 0, 0);
        handshake();

        // writes during a frame and on the start edge; start while busy
        run_frame(0, 1, 0, 0);
        handshake();
        run_frame(0, 0, 1, 0);
        handshake();
        run_frame(0, 0, 0, 1);
        handshake();
        cycle(); cycle(); cycle();
        chk("start_not_queued", 32'(s_busy), 0);

        // auto refresh with rotation, auto dropped during the third frame
        exp_act = exp_shadow;
        auto_mode = 1; rotate = 1; rl = 1;
        push_frame(exp_off);
        for (int f = 0; f < 3; f++) begin
            s0 = sends_seen; n = 0;
            while (sends_seen == s0 && n < 60) begin
                cycle(); n++;
                if (f == 2 && exp_q.size() < 10) auto_mode = 0;
            end
            chk("auto_send_seen", sends_seen, s0 + 1);
            handshake();
            exp_off = (exp_off + 1) % NP;
            if (f < 2) begin
                push_frame(exp_off);
                m = 0;
                do begin cycle(); m++; end while (!s_load && m < 40);
                chk("hold_gap", m, FP + 1);
            end
        end
        cycle();
        chk("auto_drop_idle", 32'(s_busy), 0);
        chk("auto_queue_empty", exp_q.size(), 0);
        rotate = 0;

        // reset while waiting in SEND
        rs = 0; rl = 1;
        exp_act = exp_shadow;
        push_frame(exp_off);
        start = 1; cycle(); start = 0;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin cycle(); n++; end
        chk("pre_reset_loads", n, 3 * NP);
        cycle(); cycle();
        chk("send_stalled_busy", 32'(s_busy), 1);
        chk("no_send_without_ready", 32'(s_send), 0);
        rs = 1; reset = 1;
        cycle();
        chk("no_send_in_reset", 32'(s_send), 0);
        reset = 0;
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++) exp_shadow[p][c] = 8'd0;
        exp_off = 0;
        cycle();
        chk("post_reset_outputs", {12'd0, s_load, s_send, s_busy, s_done, s_pix, s_col, s_lvl}, 0);
        chk("post_reset_count", 32'(frame_count), 0);
        run_frame(0, 0, 0, 0);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
